// File: rtl/pic_pkg.sv
// Purpose: shared types, sizes and the lowest-set-bit priority encoder for the 8259 INTA path.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package pic_pkg;

    localparam int IR_COUNT = 8;
    localparam int LEVEL_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK1,
        WAIT2,
        ACK2
    } pic_state_t;

    // Result of a priority encode: found is 0 when the input vector is empty.
    typedef struct packed {
        logic               found;
        logic [LEVEL_W-1:0] level;
    } prio_t;

    // Lowest-index set bit wins (IR0 highest priority). Scanning from the top
    // down lets the last hit, i.e. the lowest index, overwrite earlier ones.
    function automatic prio_t prio_enc(input logic [IR_COUNT-1:0] v);
        prio_t r;
        r.found = 1'b0;
        r.level = '0;
        for (int i = IR_COUNT - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.found = 1'b1;
                r.level = i[LEVEL_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Purpose: fully-nested priority resolution of unmasked requests against the in-service register.
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: irr_in/imr/isr (8b) in; win_level (3b) and win_vld out. A winner is valid only when
//        it outranks (strictly lower index than) every level currently in service.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [IR_COUNT-1:0] irr_in,
    input  logic [IR_COUNT-1:0] imr,
    input  logic [IR_COUNT-1:0] isr,
    output logic [LEVEL_W-1:0]  win_level,
    output logic                win_vld
);

    prio_t req_p;
    prio_t isr_p;

    always_comb begin
        req_p     = prio_enc(irr_in & ~imr);
        isr_p     = prio_enc(isr);
        win_level = req_p.level;
        win_vld   = req_p.found && (!isr_p.found || (req_p.level < isr_p.level));
    end

endmodule

// File: rtl/pic_inta_responder.sv
// Purpose: CPU-side 8259 end: raises INT, runs the two-pulse INTA ack, maintains ISR, handles EOI.
// Latency: int_out 1 cycle after a valid request; vector on data_out 1 cycle after the 2nd INTA fall.
// Backpressure: none; the CPU paces the handshake and a stalled second INTA aborts after ACK_TIMEOUT.
// Ports: clk, rst (sync, active-high); irr_in, imr, vector_base, inta_n, eoi in;
//        int_out, irr_clear (1-cycle one-hot), isr, data_out, data_oe out (all registered).
// Build option: define PIC_AUTO_EOI_EN to clear the serviced ISR bit on the final INTA rise.
module pic_inta_responder
    import pic_pkg::*;
#(
    parameter int SPURIOUS_LEVEL = 7,
    parameter int ACK_TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IR_COUNT-1:0] irr_in,
    input  logic [IR_COUNT-1:0] imr,
    input  logic [4:0]          vector_base,
    input  logic                inta_n,
    input  logic                eoi,
    output logic                int_out,
    output logic [IR_COUNT-1:0] irr_clear,
    output logic [IR_COUNT-1:0] isr,
    output logic [7:0]          data_out,
    output logic                data_oe
);

    localparam int                 CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(ACK_TIMEOUT);
    localparam logic [LEVEL_W-1:0] SPUR_LVL = LEVEL_W'(SPURIOUS_LEVEL);

    pic_state_t          state_q, state_d;
    logic                int_out_q, int_out_d;
    logic [IR_COUNT-1:0] irr_clear_q, irr_clear_d;
    logic [IR_COUNT-1:0] isr_q, isr_d;
    logic [7:0]          data_out_q, data_out_d;
    logic                data_oe_q, data_oe_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                inta_n_q;
`ifdef PIC_AUTO_EOI_EN
    // Distinguishes a real IR7 service from a spurious level-7 report.
    logic                spur_q, spur_d;
`endif

    logic               inta_fall;
    logic               inta_rise;
    logic [LEVEL_W-1:0] win_level;
    logic               win_vld;
    prio_t              isr_lo;

    pic_priority_resolver u_resolver (
        .irr_in    (irr_in),
        .imr       (imr),
        .isr       (isr_q),
        .win_level (win_level),
        .win_vld   (win_vld)
    );

    assign inta_fall = inta_n_q & ~inta_n;
    assign inta_rise = ~inta_n_q & inta_n;

    always_comb begin
        state_d     = state_q;
        int_out_d   = int_out_q;
        irr_clear_d = '0;
        isr_d       = isr_q;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
`ifdef PIC_AUTO_EOI_EN
        spur_d      = spur_q;
`endif

        // Non-specific EOI acts on the ISR as it stood before this cycle's
        // updates; a same-cycle set at the first INTA can never hit this bit
        // because the winner must outrank the lowest in-service level.
        isr_lo = prio_enc(isr_q);
        if (eoi && isr_lo.found) begin
            isr_d[isr_lo.level] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // INTA activity here is deliberately ignored.
                if (win_vld) begin
                    state_d   = REQ;
                    int_out_d = 1'b1;
                end
            end
            REQ: begin
                // int_out stays up even if the request vanishes; the CPU
                // will still acknowledge and receive the spurious level.
                if (inta_fall) begin
                    int_out_d = 1'b0;
                    state_d   = ACK1;
                    if (win_vld) begin
                        level_d          = win_level;
                        isr_d[win_level] = 1'b1;
                        irr_clear_d      = {{(IR_COUNT-1){1'b0}}, 1'b1} << win_level;
`ifdef PIC_AUTO_EOI_EN
                        spur_d           = 1'b0;
`endif
                    end else begin
                        level_d = SPUR_LVL;
`ifdef PIC_AUTO_EOI_EN
                        spur_d  = 1'b1;
`endif
                    end
                end
            end
            ACK1: begin
                if (inta_rise) begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end
            end
            WAIT2: begin
                // A fall on the final counted cycle still wins over the abort.
                if (inta_fall) begin
                    data_out_d = {vector_base, level_q};
                    data_oe_d  = 1'b1;
                    state_d    = ACK2;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    data_oe_d  = 1'b0;
                    data_out_d = '0;
                    state_d    = IDLE;
`ifdef PIC_AUTO_EOI_EN
                    if (!spur_q) begin
                        isr_d[level_q] = 1'b0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            int_out_q   <= 1'b0;
            irr_clear_q <= '0;
            isr_q       <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            level_q     <= '0;
            cnt_q       <= '0;
            inta_n_q    <= 1'b1;
`ifdef PIC_AUTO_EOI_EN
            spur_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            int_out_q   <= int_out_d;
            irr_clear_q <= irr_clear_d;
            isr_q       <= isr_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            inta_n_q    <= inta_n;
`ifdef PIC_AUTO_EOI_EN
            spur_q      <= spur_d;
`endif
        end
    end

    assign int_out   = int_out_q;
    assign irr_clear = irr_clear_q;
    assign isr       = isr_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;

endmodule

// File: doc/pic_inta_responder.md
Name: pic_inta_responder

Overview:
- CPU-side end of the 8259 interrupt path.
- Consumes the latched request vector from the IRR block and the mask register, then resolves fully-nested priority (IR0 highest).
- Raises INT to the CPU and services the two-pulse INTA acknowledge sequence: it sets the in-service bit, clears the serviced IRR bit and drives the 8-bit vector on the second pulse.
- Also maintains the ISR and handles non-specific EOI.

Parameters:
- SPURIOUS_LEVEL, 7, level reported when no valid request exists at the first INTA.
- ACK_TIMEOUT, 255, max clk cycles from the first INTA rising edge to the second INTA falling edge before abort; counter width $clog2(ACK_TIMEOUT+1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- irr_in  input  8  pending requests from IRR.
- imr  input  8  mask; 1 = level masked.
- vector_base  input  5  T7..T3 of the vector (ICW2).
- inta_n  input  1  CPU acknowledge, active low; synchronous to clk.
- eoi  input  1  one-cycle non-specific EOI strobe.
- int_out  output  1  interrupt request to CPU.
- irr_clear  output  8  one-hot, one-cycle pulse clearing the serviced IRR bit.
- isr  output  8  in-service register.
- data_out  output  8  vector byte.
- data_oe  output  1  data_out valid/drive enable.

Behaviour:
- Reset (rst=1 at a clk edge): int_out=0, irr_clear=0, isr=0, data_out=0, data_oe=0, state=IDLE, timeout counter=0, inta_n_q=1. Reset mid-sequence aborts immediately; there is no partial vector output.
- Edge detect: inta_n_q is the registered inta_n.
  - fall = inta_n_q & ~inta_n
  - rise = ~inta_n_q & inta_n
- Candidate: req = irr_in & ~imr. The winner is the lowest-index set bit of req. It is valid only if its index is strictly lower than the lowest-index set bit of isr, or isr=0.
- IDLE: if a valid winner exists, go to REQ and int_out=1 on the next edge (1-cycle latency).
- REQ: int_out held at 1 even if the request disappears. On fall:
  - If a winner is valid, latch its level, set isr[level] and pulse irr_clear[level] for 1 cycle.
  - Otherwise latch SPURIOUS_LEVEL with no isr set and no irr_clear.
  - int_out=0 next cycle; go to ACK1.
- ACK1: wait for rise, then go to WAIT2 and clear the counter.
- WAIT2: counter increments each cycle.
  - On fall: data_out={vector_base,level}, data_oe=1 next cycle; go to ACK2.
  - If the counter reaches ACK_TIMEOUT first: go to IDLE, isr retained, data_oe stays 0.
- ACK2: data_oe held 1 while inta_n low. On rise: data_oe=0, data_out=0, go to IDLE. A new INT may then be raised next cycle.
- EOI: on eoi=1, clear the lowest-index set bit of isr as it stood before this cycle's update. If isr=0, no effect.
  - If EOI coincides with an ISR set at the first INTA, both apply. They cannot hit the same bit.
- An INTA fall in IDLE is ignored and drives no data.
- irr_in/imr changes after the first INTA fall do not alter the latched level.

Optional Feature:
- Macro: PIC_AUTO_EOI_EN.
- Defined: on the ACK2 rise, isr[level] is cleared automatically in the same cycle the FSM returns to IDLE. Spurious cycles still clear nothing. The eoi port remains functional.
- Undefined: isr bits are cleared only by eoi or rst.

Decomposition:
- Shared package pic_pkg holds:
  - state enum {IDLE, REQ, ACK1, WAIT2, ACK2}
  - IR_COUNT=8, LEVEL_W=3
  - a priority-encode function (lowest set bit, with found flag), reused by the IRR and ISR logic
- One sub-module: pic_priority_resolver, combinational. Inputs irr_in, imr, isr; outputs winner level and valid.

Test Plan:
- Single request: irr_in=8'b0000_0100, imr=0, vector_base=5'h08. Required: int_out=1 one cycle later; on the first INTA fall isr=8'h04 and irr_clear=8'h04 for 1 cycle; on the second INTA fall data_out=8'h42 with data_oe=1; data_oe=0 after the rise.
- Nesting: isr=8'h08 from a prior IR3 service, then irr_in=8'h20. Required: int_out stays 0. Then irr_in=8'h02. Required: int_out=1, vector level=1, isr=8'h0A.
- Spurious: raise int_out via IR5, drop irr_in to 0 before the first INTA. Required: data_out={vector_base,3'd7}, isr unchanged, irr_clear stays 0.
- EOI with isr=8'h0A. Required: isr=8'h08 after one eoi, 8'h00 after a second.
- Timeout: no second INTA within 255 cycles. Required: return to IDLE, data_oe never asserted, isr bit kept. With PIC_AUTO_EOI_EN defined, a normal cycle must leave isr=0 after the ACK2 rise.
- rst asserted during ACK2. Required: data_oe=0, int_out=0, isr=0 the next cycle.
